rr_arbiter: RTL and testbench



---
 rtl/rr_arbiter.sv | 100 ++++++++++
 tb/tb_rr_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: N requesters share one resource. The priority pointer
// rotates downward from the last winner, skipping idle channels. A holder keeps
// its grant while it requests, unless MAX_HOLD cycles are used up and another
// channel is waiting.
module rr_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 0,
  localparam int unsigned IW      = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_id,
  output logic          grant_valid
);

  localparam int unsigned CW = 8;

  // Highest-priority channel index; priority descends from here with wrap
  logic [IW-1:0] ptr;
  logic [CW-1:0] hold_cnt;

  logic [CW-1:0] hold_max;
  logic [N-1:0]  cand;
  logic          holder_req;
  logic          others;
  logic          limit_hit;
  logic          arb;
  logic          found;
  logic [IW-1:0] win_id;

  logic [N-1:0]  grant_nxt;
  logic [IW-1:0] grant_id_nxt;
  logic          grant_valid_nxt;
  logic [IW-1:0] ptr_nxt;
  logic [CW-1:0] hold_cnt_nxt;

  // Arbitration decision, pointer scan and next-state computation
  always_comb begin
    hold_max        = (MAX_HOLD == 0) ? CW'(255) : CW'(MAX_HOLD);
    holder_req      = |(req & grant);
    others          = |(req & ~grant);
    limit_hit       = (MAX_HOLD != 0) && (hold_cnt == hold_max) && others;
    arb             = !grant_valid || !holder_req || limit_hit;
    // The holder never competes in a rescan: either it dropped or it is over limit
    cand            = req & ~grant;
    found           = 1'b0;
    win_id          = '0;
    grant_nxt       = grant;
    grant_id_nxt    = grant_id;
    grant_valid_nxt = grant_valid;
    ptr_nxt         = ptr;
    hold_cnt_nxt    = hold_cnt;

    for (int i = 0; i < int'(N); i++) begin
      int idx;
      idx = (int'(ptr) + int'(N) - i) % int'(N);
      if (!found && cand[idx]) begin
        found  = 1'b1;
        win_id = IW'(idx);
      end
    end

    if (arb) begin
      if (found) begin
        grant_nxt       = N'(1) << win_id;
        grant_id_nxt    = win_id;
        grant_valid_nxt = 1'b1;
        ptr_nxt         = (win_id == '0) ? IW'(N - 1) : win_id - IW'(1);
        hold_cnt_nxt    = CW'(1);
      end else begin
        grant_nxt       = '0;
        grant_id_nxt    = '0;
        grant_valid_nxt = 1'b0;
        hold_cnt_nxt    = '0;
      end
    end else if (hold_cnt != hold_max) begin
      hold_cnt_nxt = hold_cnt + CW'(1);
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      ptr         <= IW'(N - 1);
      hold_cnt    <= '0;
    end else begin
      grant       <= grant_nxt;
      grant_id    <= grant_id_nxt;
      grant_valid <= grant_valid_nxt;
      ptr         <= ptr_nxt;
      hold_cnt    <= hold_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: three configurations checked every cycle against a
// behavioural model, plus hand-computed literal expectations.
module tb_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_a, grant_a;
  logic [1:0] id_a;
  logic       valid_a;
  logic [3:0] req_b, grant_b;
  logic [1:0] id_b;
  logic       valid_b;
  logic [4:0] req_c, grant_c;
  logic [2:0] id_c;
  logic       valid_c;

  int checks;
  int errors;

  rr_arbiter #(.N(4), .MAX_HOLD(0)) u_a (
    .clk(clk), .reset_n(rst_n), .req(req_a),
    .grant(grant_a), .grant_id(id_a), .grant_valid(valid_a));
  rr_arbiter #(.N(4), .MAX_HOLD(3)) u_b (
    .clk(clk), .reset_n(rst_n), .req(req_b),
    .grant(grant_b), .grant_id(id_b), .grant_valid(valid_b));
  rr_arbiter #(.N(5), .MAX_HOLD(4)) u_c (
    .clk(clk), .reset_n(rst_n), .req(req_c),
    .grant(grant_c), .grant_id(id_c), .grant_valid(valid_c));

  always #5 clk = ~clk;

  // Model state: who holds the resource, who has top priority, cycles held
  typedef struct {
    int holder;
    int top;
    int held;
  } mstate_t;

  mstate_t sa, sb, sc;

  function automatic mstate_t mreset(int n);
    mstate_t s;
    s.holder = -1;
    s.top    = n - 1;
    s.held   = 0;
    return s;
  endfunction

  function automatic mstate_t mstep(int n, int mh, logic [31:0] r, mstate_t s);
    mstate_t o;
    bit      waiting;
    int      cap;
    o       = s;
    waiting = 0;
    cap     = (mh == 0) ? 255 : mh;
    for (int k = 0; k < n; k++)
      if (k != s.holder && r[k]) waiting = 1;
    if (s.holder >= 0 && r[s.holder] && !(mh != 0 && s.held >= mh && waiting)) begin
      o.held = (s.held + 1 > cap) ? cap : s.held + 1;
      return o;
    end
    o.holder = -1;
    o.held   = 0;
    for (int d = 0; d < n; d++) begin
      int c;
      c = (s.top - d + n) % n;
      if (o.holder < 0 && r[c] && c != s.holder) o.holder = c;
    end
    if (o.holder >= 0) begin
      o.top  = (o.holder + n - 1) % n;
      o.held = 1;
    end
    return o;
  endfunction

  task automatic cmp(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  task automatic cmp_model(string name, mstate_t s, logic [31:0] g, logic [31:0] id, logic v);
    logic [31:0] eg;
    eg = (s.holder >= 0) ? (32'd1 << s.holder) : 32'd0;
    cmp({name, ".grant"}, g, eg);
    cmp({name, ".grant_id"}, id, (s.holder >= 0) ? 32'(s.holder) : 32'd0);
    cmp({name, ".grant_valid"}, 32'(v), (s.holder >= 0) ? 32'd1 : 32'd0);
  endtask

  task automatic reset_models();
    sa = mreset(4);
    sb = mreset(4);
    sc = mreset(5);
  endtask

  // One clock: advance the models with the applied requests, then compare
  task automatic tick();
    @(posedge clk);
    if (!rst_n) reset_models();
    else begin
      sa = mstep(4, 0, 32'(req_a), sa);
      sb = mstep(4, 3, 32'(req_b), sb);
      sc = mstep(5, 4, 32'(req_c), sc);
    end
    #1;
    cmp_model("a", sa, 32'(grant_a), 32'(id_a), valid_a);
    cmp_model("b", sb, 32'(grant_b), 32'(id_b), valid_b);
    cmp_model("c", sc, 32'(grant_c), 32'(id_c), valid_c);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    req_a = '0;
    req_b = '0;
    req_c = '0;
    reset_models();
    tick();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic step_a(logic [3:0] r, logic [3:0] exp_g, string name);
    req_a = r;
    tick();
    cmp(name, 32'(grant_a), 32'(exp_g));
  endtask

  task automatic step_b(logic [3:0] r, logic [3:0] exp_g, string name);
    req_b = r;
    tick();
    cmp(name, 32'(grant_b), 32'(exp_g));
  endtask

  int          wait_cnt [5];
  int          max_wait;
  logic [4:0]  applied;

  initial begin
    clk    = 1'b0;
    rst_n  = 1'b0;
    req_a  = '0;
    req_b  = '0;
    req_c  = '0;
    checks = 0;
    errors = 0;
    reset_models();
    #1;
    cmp("reset_grant", 32'(grant_a), 32'd0);
    cmp("reset_valid", 32'(valid_b), 32'd0);
    tick();
    #2;
    rst_n = 1'b1;

    // Hold with all requesting, then holder drop moves to channel 2
    step_a(4'b1111, 4'b1000, "a_first");
    step_a(4'b1111, 4'b1000, "a_hold1");
    step_a(4'b1111, 4'b1000, "a_hold2");
    step_a(4'b0111, 4'b0100, "a_drop3");
    cmp("a_drop3_id", 32'(id_a), 32'd2);

    // Each holder drops after one cycle: full rotation with wrap
    do_reset();
    step_a(4'b1111, 4'b1000, "a_rot0");
    step_a(4'b0111, 4'b0100, "a_rot1");
    step_a(4'b1011, 4'b0010, "a_rot2");
    step_a(4'b1101, 4'b0001, "a_rot3");
    step_a(4'b1110, 4'b1000, "a_rot4");

    // Sparse requests: idle channels are skipped
    do_reset();
    step_a(4'b0101, 4'b0100, "a_sk0");
    step_a(4'b0101, 4'b0100, "a_sk1");
    step_a(4'b0001, 4'b0001, "a_sk2");
    step_a(4'b0101, 4'b0001, "a_sk3");
    step_a(4'b0100, 4'b0100, "a_sk4");
    req_a = '0;

    // MAX_HOLD=3 alternation between channels 3 and 0
    step_b(4'b1001, 4'b1000, "b_alt0");
    step_b(4'b1001, 4'b1000, "b_alt1");
    step_b(4'b1001, 4'b1000, "b_alt2");
    step_b(4'b1001, 4'b0001, "b_alt3");
    step_b(4'b1001, 4'b0001, "b_alt4");
    step_b(4'b1001, 4'b0001, "b_alt5");
    step_b(4'b1001, 4'b1000, "b_alt6");
    // Lone requester keeps the grant past the limit
    for (int i = 0; i < 6; i++) step_b(4'b0010, 4'b0010, "b_lone");

    // Asynchronous reset mid-grant, then pointer back at channel 3
    #2;
    rst_n = 1'b0;
    reset_models();
    #1;
    cmp("b_async_grant", 32'(grant_b), 32'd0);
    cmp("b_async_id", 32'(id_b), 32'd0);
    cmp("b_async_valid", 32'(valid_b), 32'd0);
    #1;
    rst_n = 1'b1;
    step_b(4'b0011, 4'b0010, "b_after_rst");
    req_b = '0;
    tick();

    // Random traffic on N=5, MAX_HOLD=4; pending requests stay high until granted
    max_wait = 0;
    for (int k = 0; k < 5; k++) wait_cnt[k] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic [4:0] nr;
      for (int k = 0; k < 5; k++) begin
        if (req_c[k] && !grant_c[k]) nr[k] = 1'b1;
        else nr[k] = ($urandom_range(0, 3) == 0);
      end
      req_c   = nr;
      applied = nr;
      tick();
      checks++;
      if (!$onehot0(grant_c) || (grant_c & ~applied) != '0) begin
        errors++;
        $display("FAIL c_legal t=%0t grant=%b req=%b", $time, grant_c, applied);
      end
      for (int k = 0; k < 5; k++) begin
        if (applied[k] && !grant_c[k]) wait_cnt[k]++;
        else wait_cnt[k] = 0;
        if (wait_cnt[k] > max_wait) max_wait = wait_cnt[k];
      end
    end
    checks++;
    if (max_wait > (5 - 1) * 4 + 5) begin
      errors++;
      $display("FAIL c_fair max_wait=%0d limit=%0d", max_wait, (5 - 1) * 4 + 5);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
